// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port write-first RAM: accepts a command
// (direction, base, length) and sequences RAM accesses behind valid/ready streams.
module ram_burst_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] remaining_reg, remaining_next;
  logic              rd_valid_reg, rd_valid_next;
  logic              done_reg, done_next;
  logic              first_reg, first_next;
  logic              en_int, we_int, rd_hs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      rd_valid_reg  <= 1'b0;
      done_reg      <= 1'b0;
      first_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      rd_valid_reg  <= rd_valid_next;
      done_reg      <= done_next;
      first_reg     <= first_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    rd_valid_next  = rd_valid_reg;
    done_next      = 1'b0;
    first_next     = first_reg;
    en_int         = 1'b0;
    we_int         = 1'b0;
    rd_hs          = 1'b0;
    cmd_ready      = 1'b0;
    wr_ready       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_next      = cmd_addr;
          remaining_next = cmd_len;
          first_next     = !cmd_write;
          state_next     = cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        en_int   = wr_valid;
        we_int   = wr_valid;
        if (wr_valid) begin
          addr_next = addr_reg + 1'b1;
          if (remaining_reg == '0) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            remaining_next = remaining_reg - 1'b1;
          end
        end
      end
      ST_READ: begin
        rd_hs  = rd_valid_reg && rd_ready;
        // Issue the next read only when the current beat leaves, so a stalled
        // beat keeps the RAM output (and rd_data) frozen.
        en_int = first_reg || (rd_hs && remaining_reg != '0);
        if (en_int) begin
          addr_next     = addr_reg + 1'b1;
          rd_valid_next = 1'b1;
          first_next    = 1'b0;
        end else if (rd_hs) begin
          rd_valid_next = 1'b0;
        end
        if (rd_hs) begin
          if (remaining_reg == '0) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            remaining_next = remaining_reg - 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Reset gates the enables directly so the reset cycle itself never touches RAM.
  assign ram_en   = en_int && rst_n;
  assign ram_we   = we_int && rst_n;
  assign ram_addr = addr_reg;
  assign ram_di   = wr_data;
  assign rd_data  = ram_do;
  assign rd_valid = rd_valid_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;

endmodule

// File: tb/tb_ram_burst_master.sv
// Randomized scoreboard bench for ram_burst_master with a behavioural RAM and
// a word-array reference model of burst effects.
module tb_ram_burst_master;
  localparam int AW = 5;
  localparam int DW = 4;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [DW-1:0] rd_data;
  logic rd_valid, rd_ready = 1'b0;
  logic busy, done, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do = '0;

  ram_burst_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-first single-port RAM
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_di;
        ram_do        <= ram_di;
      end else begin
        ram_do <= mem[ram_addr];
      end
    end
  end

  logic [DW-1:0] ref_mem [DEPTH];
  int wq_addr[$];
  int wq_data[$];
  int rq_data[$];
  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;
  int rd_first_cyc = -1;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  bit gap_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected writes/reads whenever the DUT presents them
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ram_en", {ram_en, ram_we}, 0);
      prev_stall = 1'b0;
    end else begin
      if (ram_en && ram_we) begin
        if (wq_addr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          chk("wr_addr", ram_addr, wq_addr.pop_front());
          chk("wr_data", ram_di, wq_data.pop_front());
        end
      end
      if (ram_en && !ram_we) begin
        issue_cnt++;
        chk("en_while_stalled", rd_valid && !rd_ready, 0);
      end
      if (prev_stall && rd_valid) chk("stall_stable", rd_data, prev_data);
      if (rd_valid && rd_first_cyc < 0) rd_first_cyc = cyc;
      if (rd_valid && rd_ready) begin
        if (rq_data.size() == 0) chk("unexpected_beat", 1, 0);
        else chk("rd_data", rd_data, rq_data.pop_front());
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
    end
  end

  task automatic send_cmd(input bit w, input int a, input int len, output int c_acc);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = AW'(a);
    cmd_len   = AW'(len);
    c_acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        c_acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (c_acc < 0) chk("cmd_timeout", 0, 1);
  endtask

  task automatic wait_done(input int c, input int rel, input string tag);
    int dc;
    dc = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wr_valid  = 1'b0;
      @(negedge clk);
      if (done) begin
        dc = cyc;
        chk("cmd_ready_at_done", cmd_ready, 1);
        break;
      end
    end
    if (dc < 0) chk({tag, "_done_timeout"}, 0, 1);
    else if (rel > 0) chk({tag, "_done_cycle"}, dc - c, rel);
    chk("wq_empty", wq_addr.size(), 0);
    chk("rq_empty", rq_data.size(), 0);
    $display("%s burst complete at cycle %0d (accepted %0d)", tag, dc, c);
  endtask

  // vmode: 0 continuous, 1 gap pattern, 2 random; dmode: 0 random, 1 address, 2 all-ones
  task automatic do_write(input int a, input int len, input int vmode, input int dmode,
                          input int abort_after, input int exp_rel);
    logic [DW-1:0] d [DEPTH];
    int n, lim, c, beat, k;
    n = len + 1;
    lim = (abort_after > 0) ? abort_after : n;
    for (int i = 0; i < n; i++)
      d[i] = (dmode == 1) ? DW'((a + i) % DEPTH) : (dmode == 2) ? '1 : DW'($urandom_range(0, 15));
    for (int i = 0; i < lim; i++) begin
      wq_addr.push_back((a + i) % DEPTH);
      wq_data.push_back(int'(d[i]));
      ref_mem[(a + i) % DEPTH] = d[i];
    end
    send_cmd(1'b1, a, len, c);
    beat = 0;
    k = 0;
    while (beat < lim && k < 400) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      case (vmode)
        0: wr_valid = 1'b1;
        1: wr_valid = gap_pat[k % 7];
        default: wr_valid = 1'($urandom_range(0, 1));
      endcase
      wr_data = d[beat];
      @(negedge clk);
      chk("we_follows_valid", ram_we, wr_valid);
      if (wr_valid && wr_ready) beat++;
      k++;
    end
    if (beat < lim) chk("wr_beat_timeout", beat, lim);
    if (abort_after > 0) begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      wr_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wr_valid = 1'b0;
      @(negedge clk);
      chk("abort_cmd_ready", cmd_ready, 1);
      chk("abort_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
        chk("abort_no_done", done, 0);
        @(posedge clk); #1;
        @(negedge clk);
      end
      chk("wq_empty", wq_addr.size(), 0);
      $display("write burst aborted by reset after %0d beats at cycle %0d", lim, cyc);
    end else begin
      wait_done(c, exp_rel, "wr");
    end
  endtask

  // rmode: 0 always ready, 1 toggle 0,1,0,1..., 2 random
  task automatic do_read(input int a, input int len, input int rmode,
                         input int exp_rel, input int exp_first);
    int n, c, beat, k;
    n = len + 1;
    for (int i = 0; i < n; i++) rq_data.push_back(int'(ref_mem[(a + i) % DEPTH]));
    issue_cnt = 0;
    rd_first_cyc = -1;
    send_cmd(1'b0, a, len, c);
    beat = 0;
    k = 0;
    while (beat < n && k < 400) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      case (rmode)
        0: rd_ready = 1'b1;
        1: rd_ready = 1'(k % 2);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (rd_valid && rd_ready) beat++;
      k++;
    end
    if (beat < n) chk("rd_beat_timeout", beat, n);
    wait_done(c, exp_rel, "rd");
    chk("rd_issue_count", issue_cnt, n);
    if (exp_first > 0) chk("rd_first_valid", rd_first_cyc - c, exp_first);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    // Reset with a command and write beat offered
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    wr_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_done", done, 0);
    $display("reset released at cycle %0d", cyc);

    do_write(3, 3, 0, 0, 0, 5);
    do_read(3, 3, 0, 6, 2);
    do_write(30, 3, 0, 0, 0, 5);
    do_read(30, 3, 0, 6, 2);
    do_write(0, 31, 0, 1, 0, 33);
    do_read(0, 31, 0, 34, 2);
    do_read(10, 3, 1, 0, 0);
    do_write(12, 3, 1, 0, 0, 8);
    do_read(12, 3, 0, 6, 2);
    do_write(8, 3, 0, 2, 0, 5);
    do_write(8, 3, 0, 0, 2, 0);
    do_read(8, 3, 0, 6, 2);

    for (int t = 0; t < 24; t++) begin
      int a, len;
      a = $urandom_range(0, DEPTH - 1);
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) do_write(a, len, 2, 0, 0, 0);
      else do_read(a, len, 2, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
